// File: rtl/secret_sched.sv
// secret_sched: round-robin front end for the shared secret_impl datapath.
// One operation is in flight at a time. The operands reach the datapath for
// exactly one cycle (ISSUE) and are held at zero otherwise, so the hidden
// accumulator only moves on real operations.
// Optional build macro SECRET_SCHED_STATS_EN adds per-requester grant counters.
module secret_sched #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*32-1:0]  req_a_i,
  input  logic [NUM_REQ*32-1:0]  req_b_i,
  output logic [31:0]            dp_a_o,
  output logic [31:0]            dp_b_o,
  input  logic [31:0]            dp_x_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [31:0]            rsp_data_o,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic                   busy_o
`ifdef SECRET_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  grant_cnt_o
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] CAPT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [31:0]     dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [ID_W-1:0] pick;
  logic            found;
  logic            accept;

  // Round-robin pick: first valid requester after the last grant, wrapping.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = last_grant_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
  end

  assign accept = (state_q == IDLE) && found;

  // Grant is one-hot on the picked requester, only while idle.
  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[pick] = 1'b1;
  end

  // Next-state logic for the FSM and the registered outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      IDLE: if (accept) begin
        dp_a_d       = req_a_i[32*int'(pick) +: 32];
        dp_b_d       = req_b_i[32*int'(pick) +: 32];
        rsp_id_d     = pick;
        last_grant_d = pick;
        state_d      = ISSUE;
      end
      ISSUE: begin
        // Datapath samples the operands at this edge; park them at zero after.
        dp_a_d  = '0;
        dp_b_d  = '0;
        state_d = CAPT;
      end
      CAPT: begin
        rsp_data_d  = dp_x_i;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      default: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State registers; last_grant resets to NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign dp_a_o      = dp_a_q;
  assign dp_b_o      = dp_b_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = (state_q != IDLE);

`ifdef SECRET_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt_q;

  // Saturating per-requester grant counters, bumped on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else if (accept && grant_cnt_q[16*int'(pick) +: 16] != 16'hFFFF) begin
      grant_cnt_q[16*int'(pick) +: 16] <= grant_cnt_q[16*int'(pick) +: 16] + 16'd1;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_secret_sched.sv
// Bench for secret_sched with NUM_REQ=3 and a stand-in accumulate/compare
// datapath: x = (acc > 10) ? b : a + b, then acc += a.
module tb_secret_sched;
  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0][31:0] req_a = '0;
  logic [N-1:0][31:0] req_b = '0;
  logic [31:0]       dp_a, dp_b, dp_x, rsp_data;
  logic              rsp_valid, busy;
  logic              rsp_ready = 1'b1;
  logic [1:0]        rsp_id;
`ifdef SECRET_SCHED_STATS_EN
  logic [N*16-1:0]   grant_cnt;
`endif

  secret_sched #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .dp_a_o(dp_a), .dp_b_o(dp_b), .dp_x_i(dp_x),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_id_o(rsp_id), .busy_o(busy)
`ifdef SECRET_SCHED_STATS_EN
    , .grant_cnt_o(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Hidden datapath stand-in; never reset, like the real accumulator.
  logic [31:0] acc_q = '0;
  logic [31:0] x_q = '0;
  always @(posedge clk) begin
    x_q   <= (acc_q > 32'd10) ? dp_b : dp_a + dp_b;
    acc_q <= acc_q + dp_a;
  end
  assign dp_x = x_q;

  int ncmp = 0;
  int nerr = 0;
  logic [31:0] acc_m = '0;   // reference accumulator
  int last_m = N - 1;        // reference last grant

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] x);
    x = (acc_m > 32'd10) ? b : a + b;
    acc_m = acc_m + a;
  endtask

  // One request from requester id, rsp_ready assumed high; checks
  // grant, one-cycle operand pulse, 3-cycle latency and the response.
  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    int n;
    req_a[id] = a;
    req_b[id] = b;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin tick(); n++; end
    check("grant", 32'(req_ready), 32'(1 << id));
    model_op(a, b, x);
    last_m = id;
    tick();
    req_valid[id] = 1'b0;
    check("issue_a", dp_a, a);
    check("issue_b", dp_b, b);
    check("busy", 32'(busy), 1);
    tick();
    check("capt_a_zero", dp_a, 0);
    n = 2;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check("latency", 32'(n), 3);
    check("rsp_data", rsp_data, x);
    check("rsp_id", 32'(rsp_id), 32'(id));
    tick();
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] exp_x[$];
    int exp_id[$];
    int nrsp, cyc, upd, eid, n;

    // Reset state
    tick();
    check("rst_ready", 32'(req_ready), 0);
    check("rst_dp_a", dp_a, 0);
    check("rst_dp_b", dp_b, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Single op then chained ops from req0
    run_op(0, 32'd3, 32'd4);
    run_op(0, 32'd5, 32'd1);
    run_op(0, 32'd4, 32'd2);
    run_op(0, 32'd1, 32'd9);

    // Fairness: all valid, random operands, fresh rotation after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_m = N - 1;
    for (int i = 0; i < N; i++) begin
      req_a[i] = $urandom_range(0, 15);
      req_b[i] = $urandom_range(0, 15);
    end
    req_valid = '1;
    #1;
    nrsp = 0; cyc = 0; upd = -1;
    while (nrsp < 6 && cyc < 60) begin
      if (upd >= 0) begin
        req_a[upd] = $urandom_range(0, 15);
        req_b[upd] = $urandom_range(0, 15);
        upd = -1;
        #1;
      end
      check("onehot", 32'($countones(req_ready) <= 1), 1);
      if (req_ready != '0) begin
        eid = (last_m + 1) % N;
        check("rr_grant", 32'(req_ready), 32'(1 << eid));
        model_op(req_a[eid], req_b[eid], x);
        exp_x.push_back(x);
        exp_id.push_back(eid);
        last_m = eid;
        upd = eid;
      end
      if (rsp_valid) begin
        if (exp_id.size() > 0) begin
          check("rr_rsp_id", 32'(rsp_id), 32'(exp_id.pop_front()));
          check("rr_rsp_data", rsp_data, exp_x.pop_front());
        end else begin
          check("rr_unexpected_rsp", 32'(rsp_valid), 0);
        end
        nrsp++;
        if (nrsp == 6) req_valid = '0;
      end
      tick();
      cyc++;
    end
    check("rr_count", 32'(nrsp), 6);

    // Backpressure: response held for 10 cycles, req0 waiting behind it
    rsp_ready = 1'b0;
    req_a[2] = 32'd5; req_b[2] = 32'd6;
    req_valid[2] = 1'b1;
    #1;
    check("bp_grant", 32'(req_ready), 32'b100);
    model_op(32'd5, 32'd6, x);
    last_m = 2;
    tick();
    req_valid[2] = 1'b0;
    req_a[0] = 32'd7; req_b[0] = 32'd8;
    req_valid[0] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_data", rsp_data, x);
      check("bp_id", 32'(rsp_id), 2);
      check("bp_ready", 32'(req_ready), 0);
      check("bp_dp_a", dp_a, 0);
      check("bp_dp_b", dp_b, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_next_grant", 32'(req_ready), 32'b001);
    check("bp_idle", 32'(busy), 0);
    model_op(32'd7, 32'd8, x);
    last_m = 0;
    tick();
    req_valid[0] = 1'b0;
    check("bp_next_dp_a", dp_a, 32'd7);
    n = 1;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check("bp_next_lat", 32'(n), 3);
    check("bp_next_data", rsp_data, x);
    check("bp_next_id", 32'(rsp_id), 0);
    tick();

    // Async reset during CAPT
    req_a[1] = 32'd2; req_b[1] = 32'd3;
    req_valid[1] = 1'b1;
    #1;
    check("ar_grant", 32'(req_ready), 32'b010);
    model_op(32'd2, 32'd3, x);  // datapath samples at end of ISSUE
    tick();
    req_valid[1] = 1'b0;
    tick();                      // CAPT
    #2 rst_n = 1'b0;
    #1;
    check("ar_rsp_valid", 32'(rsp_valid), 0);
    check("ar_rsp_data", rsp_data, 0);
    check("ar_rsp_id", 32'(rsp_id), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_dp_a", dp_a, 0);
    check("ar_ready", 32'(req_ready), 0);
    tick();
    rst_n = 1'b1;
    last_m = N - 1;
    req_a[1] = 32'd1; req_b[1] = 32'd1;
    req_valid[1] = 1'b1;
    req_a[0] = 32'd2; req_b[0] = 32'd2;
    req_valid[0] = 1'b1;
    #1;
    check("ar_first_grant", 32'(req_ready), 32'b001);
    run_op(0, 32'd2, 32'd2);
    req_valid[1] = 1'b0;

`ifdef SECRET_SCHED_STATS_EN
    for (int i = 0; i < 5; i++) run_op(1, $urandom_range(0, 15), $urandom_range(0, 15));
    check("cnt_req1", 32'(grant_cnt[31:16]), 5);
    check("cnt_req0", 32'(grant_cnt[15:0]), 1);
    force dut.grant_cnt_q = '1;
    tick();
    release dut.grant_cnt_q;
    run_op(1, 32'd1, 32'd1);
    check("cnt_sat", 32'(grant_cnt[31:16]), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
